// File: rtl/masked_sbox_pipe_if.sv
// masked_sbox_pipe_if: valid/ready stream bundle for the masked S-box pipeline
interface masked_sbox_pipe_if #(parameter int LANES = 4);
  logic                 in_valid;
  logic                 in_ready;
  logic                 in_encrypt;
  logic [8*LANES-1:0]   in_a;
  logic [8*LANES-1:0]   in_m;
  logic [8*LANES-1:0]   in_n;
  logic                 flush;
  logic                 out_valid;
  logic                 out_ready;
  logic [8*LANES-1:0]   out_q;
  logic [8*LANES-1:0]   out_n;
  logic                 mask_err;
  modport master (
    output in_valid, in_encrypt, in_a, in_m, in_n, flush, out_ready,
    input  in_ready, out_valid, out_q, out_n, mask_err
  );
  modport slave (
    input  in_valid, in_encrypt, in_a, in_m, in_n, flush, out_ready,
    output in_ready, out_valid, out_q, out_n, mask_err
  );
endinterface

// File: rtl/masked_sbox_pipe.sv
// masked_sbox_pipe: multi-lane first-order masked AES S-box / inverse S-box stall pipeline
module masked_sbox_pipe #(
  parameter int LANES  = 4,
  parameter int STAGES = 2
) (
  input logic               clk,
  input logic               rst,
  masked_sbox_pipe_if.slave bus
);
  localparam int W = 8 * LANES;
  function automatic logic [7:0] gmul(input logic [7:0] ga, input logic [7:0] gb);
    logic [7:0] pr;
    logic [7:0] sh;
    pr = 8'h00;
    sh = ga;
    for (int k = 0; k < 8; k++) begin
      pr = pr ^ (gb[k] ? sh : 8'h00);
      sh = {sh[6:0], 1'b0} ^ (sh[7] ? 8'h1b : 8'h00);
    end
    return pr;
  endfunction
  function automatic logic [7:0] sq(input logic [7:0] s);
    return gmul(s, s);
  endfunction
  function automatic logic [7:0] lmap(input logic [7:0] y);
    return y ^ {y[6:0], y[7]} ^ {y[5:0], y[7:6]} ^ {y[4:0], y[7:5]} ^ {y[3:0], y[7:4]};
  endfunction
  function automatic logic [7:0] linv(input logic [7:0] y);
    return {y[6:0], y[7]} ^ {y[4:0], y[7:5]} ^ {y[1:0], y[7:2]};
  endfunction
  function automatic logic [7:0] mmul(input logic [7:0] xa, input logic [7:0] ma,
                                      input logic [7:0] xb, input logic [7:0] mb,
                                      input logic [7:0] mc);
    return gmul(xa, xb) ^ mc ^ gmul(xa, mb) ^ gmul(ma, xb) ^ gmul(ma, mb);
  endfunction
  function automatic logic [7:0] minv(input logic [7:0] xd, input logic [7:0] xm,
                                      input logic [7:0] xo);
    logic [7:0] x2, m2, x3, x12, m4, x14, x15, x240, m16;
    x2   = sq(xd);
    m2   = sq(xm);
    x3   = mmul(x2, m2, xd, xm, xm);
    x12  = sq(sq(x3));
    m4   = sq(sq(xm));
    x15  = mmul(x12, m4, x3, xm, xm);
    x14  = mmul(x12, m4, x2, m2, xm);
    x240 = sq(sq(sq(sq(x15))));
    m16  = sq(sq(sq(sq(xm))));
    return mmul(x240, m16, x14, xm, xo);
  endfunction
  logic [W-1:0] p0_d, p0_v, p0_w, p1_y, p2_q;
  logic [W-1:0] a_d, a_m, a_w, a_n, sa_d, sa_m, sa_w, sa_n;
  logic [W-1:0] b_y, b_n, sb_y, sb_n, c_q, c_n;
  logic a_v, a_e, b_v, b_e, c_v, err;
  logic sa_v, sa_e, sb_v, sb_e;
  logic a_rdy, b_rdy, c_rdy, acc, zero;
  always_comb begin
    p0_d = '0;
    p0_v = '0;
    p0_w = '0;
    zero = 1'b0;
    for (int i = 0; i < LANES; i++) begin
      p0_d[8*i +: 8] = bus.in_encrypt ? bus.in_a[8*i +: 8] : linv(bus.in_a[8*i +: 8]) ^ 8'h05;
      p0_v[8*i +: 8] = bus.in_encrypt ? bus.in_m[8*i +: 8] : linv(bus.in_m[8*i +: 8]);
      p0_w[8*i +: 8] = bus.in_encrypt ? linv(bus.in_n[8*i +: 8]) : bus.in_n[8*i +: 8];
      zero = zero | (bus.in_m[8*i +: 8] == 8'h00) | (bus.in_n[8*i +: 8] == 8'h00);
    end
  end
  assign sa_v = (STAGES == 3) ? a_v : bus.in_valid;
  assign sa_e = (STAGES == 3) ? a_e : bus.in_encrypt;
  assign sa_d = (STAGES == 3) ? a_d : p0_d;
  assign sa_m = (STAGES == 3) ? a_m : p0_v;
  assign sa_w = (STAGES == 3) ? a_w : p0_w;
  assign sa_n = (STAGES == 3) ? a_n : bus.in_n;
  always_comb begin
    p1_y = '0;
    for (int i = 0; i < LANES; i++)
      p1_y[8*i +: 8] = minv(sa_d[8*i +: 8], sa_m[8*i +: 8], sa_w[8*i +: 8]);
  end
  assign sb_v = (STAGES >= 2) ? b_v : sa_v;
  assign sb_e = (STAGES >= 2) ? b_e : sa_e;
  assign sb_y = (STAGES >= 2) ? b_y : p1_y;
  assign sb_n = (STAGES >= 2) ? b_n : sa_n;
  always_comb begin
    p2_q = '0;
    for (int i = 0; i < LANES; i++)
      p2_q[8*i +: 8] = sb_e ? lmap(sb_y[8*i +: 8]) ^ 8'h63 : sb_y[8*i +: 8];
  end
  assign c_rdy         = ~c_v | bus.out_ready;
  assign b_rdy         = (STAGES >= 2) ? (~b_v | c_rdy) : c_rdy;
  assign a_rdy         = (STAGES == 3) ? (~a_v | b_rdy) : b_rdy;
  assign bus.in_ready  = a_rdy & ~bus.flush;
  assign acc           = bus.in_valid & bus.in_ready;
  assign bus.out_valid = c_v;
  assign bus.out_q     = c_q;
  assign bus.out_n     = c_n;
  assign bus.mask_err  = err;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_v <= 1'b0;
      b_v <= 1'b0;
      c_v <= 1'b0;
      c_q <= '0;
      c_n <= '0;
      err <= 1'b0;
    end else if (bus.flush) begin
      a_v <= 1'b0;
      b_v <= 1'b0;
      c_v <= 1'b0;
      err <= 1'b0;
    end else begin
      if (a_rdy) a_v <= bus.in_valid;
      if (b_rdy) b_v <= sa_v;
      if (c_rdy) c_v <= sb_v;
      if (c_rdy & sb_v) begin
        c_q <= p2_q;
        c_n <= sb_n;
      end
      if (acc & zero) err <= 1'b1;
    end
  end
  always_ff @(posedge clk) begin
    if (acc) begin
      a_e <= bus.in_encrypt;
      a_d <= p0_d;
      a_m <= p0_v;
      a_w <= p0_w;
      a_n <= bus.in_n;
    end
    if (b_rdy & sa_v & ~bus.flush) begin
      b_e <= sa_e;
      b_y <= p1_y;
      b_n <= sa_n;
    end
  end
endmodule

// File: tb/tb_masked_sbox_pipe.sv
// tb_masked_sbox_pipe: directed and randomized checks of masked_sbox_pipe against a table-based S-box model
module tb_masked_sbox_pipe;
  logic clk, rst, rrst;
  int checks = 0;
  int errors = 0;
  logic [2:0] done = 3'b000;
  logic [7:0] sbox [256];
  logic [7:0] isbox [256];
  logic [31:0] q, qn, ra, rm, rn;
  logic re, acc;
  int lat, idx, oidx;
  logic te [8];
  logic [31:0] ta [8], tm [8], tn [8];
  masked_sbox_pipe_if #(.LANES(4)) d ();
  masked_sbox_pipe #(.LANES(4), .STAGES(2)) dut (.clk(clk), .rst(rst), .bus(d));
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end
  initial begin
    rrst = 1'b1;
    #23 rrst = 1'b0;
  end
  task automatic chk(input string tag, input logic [79:0] got, input logic [79:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask
  function automatic logic [7:0] gm(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] r;
    logic [7:0] x;
    logic [7:0] y;
    r = 0;
    x = a;
    y = b;
    while (y != 0) begin
      if (y[0]) r = r ^ x;
      x = x[7] ? ((x << 1) ^ 8'h1b) : (x << 1);
      y = y >> 1;
    end
    return r;
  endfunction
  function automatic logic [7:0] aff(input logic [7:0] b);
    logic [7:0] r;
    logic [7:0] c;
    c = 8'h63;
    for (int i = 0; i < 8; i++)
      r[i] = b[i] ^ b[(i+4)%8] ^ b[(i+5)%8] ^ b[(i+6)%8] ^ b[(i+7)%8] ^ c[i];
    return r;
  endfunction
  function automatic logic [31:0] ref_q(input logic e, input logic [31:0] a, input logic [31:0] m,
                                        input logic [31:0] n);
    logic [31:0] r;
    logic [7:0] x;
    for (int i = 0; i < 4; i++) begin
      x = a[8*i +: 8] ^ m[8*i +: 8];
      r[8*i +: 8] = (e ? sbox[x] : isbox[x]) ^ n[8*i +: 8];
    end
    return r;
  endfunction
  task automatic run1(input logic e, input logic [31:0] a, input logic [31:0] m, input logic [31:0] n,
                      output logic [31:0] oq, output logic [31:0] on, output int olat);
    int k;
    @(posedge clk); #1;
    d.in_encrypt = e;
    d.in_a = a;
    d.in_m = m;
    d.in_n = n;
    d.in_valid = 1'b1;
    d.out_ready = 1'b1;
    k = 0;
    @(negedge clk);
    while (!d.in_ready && k < 20) begin
      @(negedge clk);
      k++;
    end
    @(posedge clk); #1;
    d.in_valid = 1'b0;
    olat = 0;
    @(negedge clk);
    olat++;
    while (!d.out_valid && olat < 20) begin
      @(negedge clk);
      olat++;
    end
    oq = d.out_q;
    on = d.out_n;
  endtask
  for (genvar g = 0; g < 3; g++) begin : rs
    masked_sbox_pipe_if #(.LANES(4)) bi ();
    masked_sbox_pipe #(.LANES(4), .STAGES(g + 1)) u (.clk(clk), .rst(rrst), .bus(bi));
    initial begin
      logic [63:0] eq [$];
      logic [63:0] e;
      logic ac, held;
      logic [31:0] hq, hn;
      int sent, got, cyc;
      string tg;
      tg = $sformatf("s%0d", g + 1);
      sent = 0; got = 0; cyc = 0; ac = 0; held = 0; hq = 0; hn = 0;
      bi.in_valid = 0; bi.in_encrypt = 0; bi.in_a = 0; bi.in_m = 0; bi.in_n = 0;
      bi.flush = 0; bi.out_ready = 0;
      #30;
      while (got < 64 && cyc < 3000) begin
        @(posedge clk); #1;
        cyc++;
        if (ac) bi.in_valid = 1'b0;
        if (!bi.in_valid && sent < 64 && $urandom_range(0, 3) != 0) begin
          bi.in_encrypt = 1'($urandom_range(0, 1));
          bi.in_a = $urandom;
          bi.in_m = $urandom;
          bi.in_n = $urandom;
          bi.in_valid = 1'b1;
          sent++;
        end
        bi.out_ready = 1'($urandom_range(0, 1));
        @(negedge clk);
        if (held) chk({tg, "_hold"}, {bi.out_valid, bi.out_q, bi.out_n}, {1'b1, hq, hn});
        ac = bi.in_valid & bi.in_ready;
        if (ac) eq.push_back({ref_q(bi.in_encrypt, bi.in_a, bi.in_m, bi.in_n), bi.in_n});
        if (bi.out_valid & bi.out_ready) begin
          if (eq.size() > 0) e = eq.pop_front();
          else e = 'x;
          chk({tg, "_q"}, {bi.out_q, bi.out_n}, e);
          got++;
        end
        held = bi.out_valid & ~bi.out_ready;
        hq = bi.out_q;
        hn = bi.out_n;
      end
      bi.in_valid = 1'b0;
      chk({tg, "_cnt"}, got, 64);
      chk({tg, "_left"}, eq.size(), 0);
      bi.out_ready = 1'b1;
      repeat (4) @(negedge clk);
      chk({tg, "_idle"}, bi.out_valid, 0);
      done[g] = 1'b1;
    end
  end
  initial begin
    logic [7:0] inv;
    for (int x = 0; x < 256; x++) begin
      inv = 0;
      for (int y = 1; y < 256; y++)
        if (gm(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      sbox[x] = aff(inv);
    end
    for (int x = 0; x < 256; x++) isbox[sbox[x]] = 8'(x);
    rst = 1'b1;
    d.in_valid = 0; d.in_encrypt = 0; d.in_a = 0; d.in_m = 0; d.in_n = 0;
    d.flush = 0; d.out_ready = 1;
    #12;
    chk("rst_valid", d.out_valid, 0);
    chk("rst_q", d.out_q, 0);
    chk("rst_n", d.out_n, 0);
    chk("rst_err", d.mask_err, 0);
    #21 rst = 1'b0;
    @(negedge clk);
    chk("rst_rdy", d.in_ready, 1);
    run1(1'b1, {4{8'hF6}}, {4{8'hA5}}, {4{8'h3C}}, q, qn, lat);
    chk("enc_lat", lat, 2);
    chk("enc_q", q, 32'hD1D1D1D1);
    chk("enc_n", qn, 32'h3C3C3C3C);
    run1(1'b0, {4{8'hD1}}, {4{8'h3C}}, {4{8'hA5}}, q, qn, lat);
    chk("dec_q", q, 32'hF6F6F6F6);
    chk("dec_n", qn, 32'hA5A5A5A5);
    run1(1'b0, {4{8'hA0}}, {4{8'hC3}}, {4{8'h5A}}, q, qn, lat);
    chk("dec0_q", q, 32'h5A5A5A5A);
    for (int i = 0; i < 8; i++) begin
      re = 1'($urandom_range(0, 1)); ra = $urandom; rm = $urandom; rn = $urandom;
      run1(re, ra, rm, rn, q, qn, lat);
      chk("lane_q", q, ref_q(re, ra, rm, rn));
      chk("lane_n", qn, rn);
    end
    chk("merr0", d.mask_err, 0);
    ra = $urandom; rm = {8'hA5, 8'h00, 8'h11, 8'h22}; rn = $urandom | 32'h01010101;
    @(posedge clk); #1;
    d.out_ready = 0; d.in_encrypt = 1; d.in_a = ra; d.in_m = rm; d.in_n = rn; d.in_valid = 1;
    @(negedge clk);
    @(posedge clk); #1;
    d.in_valid = 0;
    @(negedge clk);
    chk("merr_set", d.mask_err, 1);
    @(negedge clk);
    chk("merr_v", d.out_valid, 1);
    chk("merr_q", d.out_q, ref_q(1'b1, ra, rm, rn));
    @(posedge clk); #1;
    d.flush = 1; d.in_valid = 1;
    @(negedge clk);
    chk("fl_rdy", d.in_ready, 0);
    @(posedge clk); #1;
    d.flush = 0; d.in_valid = 0;
    @(negedge clk);
    chk("fl_v", d.out_valid, 0);
    chk("fl_err", d.mask_err, 0);
    d.out_ready = 1;
    repeat (3) @(negedge clk);
    chk("fl_gone", d.out_valid, 0);
    @(posedge clk); #1;
    d.out_ready = 0; d.in_encrypt = 1; d.in_a = $urandom; d.in_m = $urandom; d.in_n = $urandom;
    d.in_valid = 1;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    chk("ar_full", {d.out_valid, d.in_ready}, 2'b10);
    #2 rst = 1'b1;
    #1;
    chk("ar_v", d.out_valid, 0);
    chk("ar_q", d.out_q, 0);
    chk("ar_n", d.out_n, 0);
    #1 rst = 1'b0;
    d.in_valid = 0;
    d.out_ready = 1;
    @(negedge clk);
    chk("ar_rdy", d.in_ready, 1);
    for (int i = 0; i < 3; i++) begin
      re = 1'($urandom_range(0, 1)); ra = $urandom; rm = $urandom; rn = $urandom;
      run1(re, ra, rm, rn, q, qn, lat);
      chk("ar_post", {q, qn}, {ref_q(re, ra, rm, rn), rn});
    end
    for (int i = 0; i < 8; i++) begin
      te[i] = 1'($urandom_range(0, 1)); ta[i] = $urandom; tm[i] = $urandom; tn[i] = $urandom;
    end
    idx = 0; oidx = 0; acc = 0;
    @(posedge clk); #1;
    d.in_encrypt = te[0]; d.in_a = ta[0]; d.in_m = tm[0]; d.in_n = tn[0]; d.in_valid = 1;
    for (int c = 0; c < 40 && oidx < 8; c++) begin
      if (c > 0) begin
        @(posedge clk); #1;
        if (acc) begin
          idx++;
          if (idx < 8) begin
            d.in_encrypt = te[idx]; d.in_a = ta[idx]; d.in_m = tm[idx]; d.in_n = tn[idx];
          end else d.in_valid = 0;
        end
      end
      d.out_ready = (c >= 7);
      @(negedge clk);
      if (c >= 2 && c < 7) chk("stl_rdy", d.in_ready, 0);
      if (c == 7) chk("go_rdy", {d.in_ready, d.out_valid}, 2'b11);
      acc = d.in_valid & d.in_ready;
      if (d.out_ready && oidx < 8) chk("nobub", d.out_valid, 1);
      if (d.out_valid & d.out_ready) begin
        chk("stl_q", {d.out_q, d.out_n}, {ref_q(te[oidx], ta[oidx], tm[oidx], tn[oidx]), tn[oidx]});
        oidx++;
      end
    end
    d.in_valid = 0;
    chk("stl_cnt", oidx, 8);
    for (int k = 0; k < 6000 && done != 3'b111; k++) @(posedge clk);
    chk("rnd_done", done, 3'b111);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
